// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the decode-stage register-hazard scoreboard.
package scoreboard_pkg;
   localparam int NREG_DEF  = 32;
   localparam int NRS_DEF   = 2;
   localparam int NWB_DEF   = 2;
   localparam int CNT_W_DEF = 2;
   localparam int REG_W     = $clog2(NREG_DEF);

   typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/sb_entry.sv
// Pending-write counter for one architectural register, with a saturating
// floor at zero and an underflow pulse when a writeback finds nothing pending.
module sb_entry #(
   parameter int CNT_W = 2,
   parameter int DEC_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             inc,
   input  logic [DEC_W-1:0] dec,
   output logic [CNT_W-1:0] cnt_o,
   output logic             underflow_o
);
   localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] dec_x;
   logic [SUM_W-1:0] next;

   always_comb begin
      sum         = SUM_W'(cnt_o) + SUM_W'(inc);
      dec_x       = SUM_W'(dec);
      next        = sum - dec_x;
      underflow_o = 1'b0;
      if (dec_x > sum) begin
         next        = '0;
         underflow_o = ~flush;  // writebacks in a flush cycle are ignored
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         cnt_o <= '0;
      else if (flush)
         cnt_o <= '0;
      else
         cnt_o <= CNT_W'(next);
   end
endmodule

// File: rtl/scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters gate issue
// on RAW hazards and counter overflow, with optional same-cycle writeback bypass.
module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NREG      = NREG_DEF,
   parameter int NRS       = NRS_DEF,
   parameter int NWB       = NWB_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int WB_BYPASS = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          iss_valid_i,
   output logic                          iss_ready_o,
   input  logic                          down_ready_i,
   input  logic [NRS*$clog2(NREG)-1:0]   rs_i,
   input  logic [NRS-1:0]                rs_used_i,
   input  logic [$clog2(NREG)-1:0]       rd_i,
   input  logic                          wen_i,
   input  logic [NWB-1:0]                wb_valid_i,
   input  logic [NWB*$clog2(NREG)-1:0]   wb_rd_i,
   input  logic                          flush_i,
   output logic [NREG-1:0]               busy_o,
   output logic                          idle_o,
   output logic                          err_o
);
   localparam int IDX_W = $clog2(NREG);
   localparam int DEC_W = $clog2(NWB + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt [NREG];
   logic [DEC_W-1:0] dec [NREG];
   logic [NREG-1:0]  uf;
   logic             hazard;
   logic             full;
   logic             fire;

   // Number of writeback ports retiring each register this cycle.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         dec[r] = '0;
         for (int j = 0; j < NWB; j++)
            if (wb_valid_i[j] && (wb_rd_i[j*IDX_W +: IDX_W] == IDX_W'(r)))
               dec[r] = dec[r] + DEC_W'(1);
      end
   end

   always_comb begin
      logic [IDX_W-1:0] src;
      hazard = 1'b0;
      src    = '0;
      for (int k = 0; k < NRS; k++) begin
         src = rs_i[k*IDX_W +: IDX_W];
         if (rs_used_i[k] && (src != '0)) begin
            if (WB_BYPASS != 0) begin
               if (int'(cnt[src]) > int'(dec[src]))
                  hazard = 1'b1;
            end else if (cnt[src] != '0) begin
               hazard = 1'b1;
            end
         end
      end
   end

   assign full        = wen_i && (rd_i != '0) && (cnt[rd_i] == CNT_MAX);
   assign iss_ready_o = down_ready_i & ~hazard & ~full & ~flush_i;
   assign fire        = iss_valid_i & iss_ready_o;

   assign cnt[0] = '0;
   assign uf[0]  = 1'b0;

   generate
      for (genvar r = 1; r < NREG; r++) begin : g_entry
         sb_entry #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
         ) u_entry (
            .clock       (clock),
            .reset       (reset),
            .flush       (flush_i),
            .inc         (fire && wen_i && (rd_i == IDX_W'(r))),
            .dec         (dec[r]),
            .cnt_o       (cnt[r]),
            .underflow_o (uf[r])
         );
      end
      for (genvar r = 0; r < NREG; r++) begin : g_busy
         assign busy_o[r] = (cnt[r] != '0);
      end
   endgenerate

   assign idle_o = ~|busy_o;

   always_ff @(posedge clock) begin
      if (reset)
         err_o <= 1'b0;
      else if (|uf)
         err_o <= 1'b1;
   end
endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios plus randomized traffic
// checked against a count-per-register reference model.
module tb_scoreboard;
   localparam int NREG = 32;
   localparam int NRS  = 2;
   localparam int NWB  = 2;
   localparam int RW   = 5;
   localparam int MAXC = 3;

   logic                clock = 1'b0;
   logic                reset;
   logic                iss_valid_i;
   logic                iss_ready_o;
   logic                down_ready_i;
   logic [NRS*RW-1:0]   rs_i;
   logic [NRS-1:0]      rs_used_i;
   logic [RW-1:0]       rd_i;
   logic                wen_i;
   logic [NWB-1:0]      wb_valid_i;
   logic [NWB*RW-1:0]   wb_rd_i;
   logic                flush_i;
   logic [NREG-1:0]     busy_o;
   logic                idle_o;
   logic                err_o;

   int errors = 0;
   int checks = 0;
   int mcnt [NREG];
   bit merr;

   always #5 clock = ~clock;

   scoreboard #(.NREG(NREG), .NRS(NRS), .NWB(NWB), .CNT_W(2), .WB_BYPASS(1)) dut (
      .clock        (clock),
      .reset        (reset),
      .iss_valid_i  (iss_valid_i),
      .iss_ready_o  (iss_ready_o),
      .down_ready_i (down_ready_i),
      .rs_i         (rs_i),
      .rs_used_i    (rs_used_i),
      .rd_i         (rd_i),
      .wen_i        (wen_i),
      .wb_valid_i   (wb_valid_i),
      .wb_rd_i      (wb_rd_i),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .idle_o       (idle_o),
      .err_o        (err_o)
   );

   // Model: may issue if no used source still has a write pending after the
   // writebacks landing this cycle, and rd has room for another writer.
   function automatic bit model_ready();
      int pend [NREG];
      int s;
      if (!down_ready_i || flush_i) return 1'b0;
      for (int r = 0; r < NREG; r++) pend[r] = mcnt[r];
      for (int j = 0; j < NWB; j++)
         if (wb_valid_i[j]) pend[int'(wb_rd_i[j*RW +: RW])] -= 1;
      for (int k = 0; k < NRS; k++) begin
         s = int'(rs_i[k*RW +: RW]);
         if (rs_used_i[k] && s != 0 && pend[s] > 0) return 1'b0;
      end
      if (wen_i && rd_i != 0 && mcnt[int'(rd_i)] == MAXC) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NREG-1:0] model_busy();
      logic [NREG-1:0] b;
      for (int r = 0; r < NREG; r++) b[r] = (mcnt[r] != 0);
      return b;
   endfunction

   task automatic clear_inputs();
      iss_valid_i  = 1'b0;
      down_ready_i = 1'b1;
      rs_i         = '0;
      rs_used_i    = '0;
      rd_i         = '0;
      wen_i        = 1'b0;
      wb_valid_i   = '0;
      wb_rd_i      = '0;
      flush_i      = 1'b0;
   endtask

   task automatic step();
      bit f;
      int n [NREG];
      f = iss_valid_i && model_ready();
      @(posedge clock);
      if (reset) begin
         for (int r = 0; r < NREG; r++) mcnt[r] = 0;
         merr = 1'b0;
      end else if (flush_i) begin
         for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      end else begin
         for (int r = 0; r < NREG; r++) n[r] = mcnt[r];
         if (f && wen_i && rd_i != 0) n[int'(rd_i)] += 1;
         for (int j = 0; j < NWB; j++)
            if (wb_valid_i[j] && wb_rd_i[j*RW +: RW] != 0) n[int'(wb_rd_i[j*RW +: RW])] -= 1;
         for (int r = 0; r < NREG; r++)
            if (n[r] < 0) begin
               n[r] = 0;
               merr = 1'b1;
            end
         for (int r = 0; r < NREG; r++) mcnt[r] = n[r];
      end
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got=%b want=1", idle_o); end
      checks++; if (busy_o !== '0) begin errors++; $display("FAIL reset_busy: got=%h want=0", busy_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got=%b want=0", err_o); end
      iss_valid_i = 1'b1;
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got=%b want=1", iss_ready_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_raw();
      iss_valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd5;
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL raw_producer: got=%b want=1", iss_ready_o); end
      step();
      clear_inputs();
      iss_valid_i = 1'b1; rs_i = {5'd0, 5'd5}; rs_used_i = 2'b01;
      #1;
      checks++; if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall: got=%b want=0", iss_ready_o); end
      checks++; if (busy_o[5] !== 1'b1) begin errors++; $display("FAIL raw_busy: got=%b want=1", busy_o[5]); end
      step();
      wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd5};
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL raw_bypass: got=%b want=1", iss_ready_o); end
      step();
      clear_inputs();
      #1;
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL raw_idle: got=%b want=1", idle_o); end
   endtask

   task automatic test_waw();
      iss_valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL waw_issue%0d: got=%b want=1", i, iss_ready_o); end
         step();
      end
      #1;
      checks++; if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL waw_full: got=%b want=0", iss_ready_o); end
      step();
      wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd7};
      #1;
      checks++; if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL waw_full_wb: got=%b want=0", iss_ready_o); end
      step();
      wb_valid_i = 2'b00;
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL waw_release: got=%b want=1", iss_ready_o); end
      step();
      clear_inputs();
      wb_valid_i = 2'b11; wb_rd_i = {5'd7, 5'd7};
      step();
      checks++; if (busy_o[7] !== 1'b1) begin errors++; $display("FAIL waw_drain_mid: got=%b want=1", busy_o[7]); end
      wb_valid_i = 2'b01;
      step();
      clear_inputs();
      checks++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL waw_drained: idle=%b err=%b want idle=1 err=0", idle_o, err_o); end
   endtask

   task automatic test_dual_wb();
      iss_valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd3;
      step();
      step();
      clear_inputs();
      checks++; if (busy_o[3] !== 1'b1) begin errors++; $display("FAIL dual_pending: got=%b want=1", busy_o[3]); end
      wb_valid_i = 2'b11; wb_rd_i = {5'd3, 5'd3};
      step();
      clear_inputs();
      checks++; if (busy_o[3] !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL dual_retire: busy3=%b err=%b want 0 0", busy_o[3], err_o); end
   endtask

   task automatic test_flush_err();
      iss_valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd4;
      step();
      rd_i = 5'd9;
      step();
      clear_inputs();
      checks++; if (idle_o !== 1'b0 || busy_o[4] !== 1'b1 || busy_o[9] !== 1'b1) begin errors++; $display("FAIL flush_pend: idle=%b b4=%b b9=%b want 0 1 1", idle_o, busy_o[4], busy_o[9]); end
      flush_i = 1'b1; iss_valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd4;
      wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd9};
      #1;
      checks++; if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got=%b want=0", iss_ready_o); end
      step();
      clear_inputs();
      checks++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL flush_clear: idle=%b err=%b want 1 0", idle_o, err_o); end
      wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd4};
      step();
      clear_inputs();
      checks++; if (err_o !== 1'b1 || busy_o[4] !== 1'b0) begin errors++; $display("FAIL underflow: err=%b b4=%b want 1 0", err_o, busy_o[4]); end
      step();
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got=%b want=1", err_o); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_reset: got=%b want=0", err_o); end
   endtask

   task automatic test_x0();
      iss_valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd0;
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL x0_issue: got=%b want=1", iss_ready_o); end
      step();
      checks++; if (idle_o !== 1'b1 || busy_o[0] !== 1'b0) begin errors++; $display("FAIL x0_idle: idle=%b b0=%b want 1 0", idle_o, busy_o[0]); end
      wen_i = 1'b0; rs_i = {5'd0, 5'd0}; rs_used_i = 2'b11;
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL x0_src: got=%b want=1", iss_ready_o); end
      step();
      clear_inputs();
      checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL x0_after: got=%b want=1", idle_o); end
   endtask

   task automatic test_random();
      bit exp_ready;
      for (int c = 0; c < 500; c++) begin
         reset        = ($urandom_range(0, 59) == 0);
         flush_i      = ($urandom_range(0, 24) == 0);
         iss_valid_i  = $urandom_range(0, 1);
         down_ready_i = ($urandom_range(0, 5) != 0);
         rs_i         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rs_used_i    = 2'($urandom_range(0, 3));
         rd_i         = 5'($urandom_range(0, 7));
         wen_i        = ($urandom_range(0, 3) != 0);
         wb_valid_i   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         wb_rd_i      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         #1;
         exp_ready = model_ready();
         checks++; if (iss_ready_o !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d: got=%b want=%b", c, iss_ready_o, exp_ready); end
         step();
         checks++; if (busy_o !== model_busy()) begin errors++; $display("FAIL rand_busy c=%0d: got=%h want=%h", c, busy_o, model_busy()); end
         checks++; if (idle_o !== (model_busy() == '0)) begin errors++; $display("FAIL rand_idle c=%0d: got=%b want=%b", c, idle_o, (model_busy() == '0)); end
         checks++; if (err_o !== merr) begin errors++; $display("FAIL rand_err c=%0d: got=%b want=%b", c, err_o, merr); end
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      merr = 1'b0;
      reset = 1'b1;
      clear_inputs();
      #1;
      test_reset();
      test_raw();
      test_waw();
      test_dual_wb();
      test_flush_err();
      test_x0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scoreboard.md
# scoreboard

Parametrised register-hazard scoreboard for the decode stage of the in-order RV64 pipeline. It replaces the single-stage rd-compare stall with a pending-write counter per architectural register. Issue of an instruction is blocked while any source it reads has an outstanding writer. Multiple in-flight writers to one register, several writeback ports, same-cycle writeback bypass and a full pipeline flush are supported.

## Interface
Parameters:
- NREG, 32: number of architectural registers; index 0 is hard-wired zero and never tracked.
- NRS, 2: source operands checked per issued instruction.
- NWB, 2: writeback ports that retire pending writes.
- CNT_W, 2: counter width; max in-flight writers per register is 2^CNT_W-1.
- WB_BYPASS, 1: 1 means a same-cycle writeback clears the hazard it resolves.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- iss_valid_i  in  1  decode holds a valid instruction
- iss_ready_o  out  1  instruction may advance to E this cycle
- down_ready_i  in  1  E stage can accept
- rs_i  in  NRS*$clog2(NREG)  source register indices, operand k at slice k
- rs_used_i  in  NRS  operand k is actually read
- rd_i  in  $clog2(NREG)  destination index
- wen_i  in  1  instruction writes rd
- wb_valid_i  in  NWB  writeback port j retires one pending write
- wb_rd_i  in  NWB*$clog2(NREG)  register retired on port j
- flush_i  in  1  all in-flight writers squashed; their writebacks are suppressed upstream
- busy_o  out  NREG  per-register "count != 0"
- idle_o  out  1  no pending writes anywhere
- err_o  out  1  sticky: a writeback hit a zero counter

## Operation
- fire = iss_valid_i & iss_ready_o.
- A source k is hazardous when rs_used_i[k] is set, rs_k != 0, and eff_cnt[rs_k] != 0.
- eff_cnt is cnt minus the number of same-cycle writebacks to that register when WB_BYPASS=1; otherwise eff_cnt = cnt.
- A destination full condition holds when wen_i, rd != 0 and cnt[rd] == max. It blocks issue (WAW overflow stall).
- iss_ready_o = down_ready_i & ~any_hazard & ~full & ~flush_i.
- Counter update per register r, next = cnt + inc - dec:
  - inc = fire & wen_i & (rd_i == r) & (r != 0).
  - dec = number of ports j with wb_valid_i[j] & (wb_rd_i[j] == r).
- Simultaneous inc and dec on the same register gives the net result. Two ports retiring the same register decrement by 2.
- Underflow: when dec > cnt + inc, the counter saturates at 0 and err_o is set. err_o clears only on reset.
- flush_i: every counter becomes 0 next cycle. Writebacks and the (blocked) issue in that cycle are ignored.
- Register 0: its counter is constant 0, busy_o[0]=0, and it is never hazardous.
- Outputs busy_o and idle_o derive from registered counts only.

## Timing
- Reset values: all counters 0, err_o=0, busy_o=0, idle_o=1. iss_ready_o equals down_ready_i once inputs are valid.
- iss_ready_o is combinational from the counters and current inputs; no added latency.
- A counter increment is visible to busy_o and to hazard checks from the cycle after fire. Back-to-back dependent instructions therefore stall until writeback.
- With WB_BYPASS=1, a dependent instruction issues in the same cycle as its producer's writeback. With WB_BYPASS=0, it issues one cycle later.
- Reset mid-operation overrides everything, including flush and writebacks, in the same edge.
- The issue handshake is valid/ready. iss_ready_o may depend on iss_valid_i-independent state only (no combinational loop through valid).

## Structure
- Shared core package holds: REG_W = $clog2(NREG), the default NREG/NRS/NWB/CNT_W constants, and the typedef for the counter type.
- Sub-module sb_entry holds one register's counter. Its ports: clock, reset, flush, inc, dec count and cnt_o. It also produces its own underflow pulse.
- The top level generates NREG-1 sb_entry instances, plus the hazard and full reduction and the err_o sticky flop.

## Test plan
- Reset, then idle: check idle_o=1, busy_o=0 and err_o=0. With iss_valid_i=1 and down_ready_i=1, iss_ready_o must be 1.
- RAW stall: issue with rd=5 and wen=1. Next cycle, offer rs1=5 used; iss_ready_o must be 0. Assert wb_valid[0] with rd=5: with WB_BYPASS=1 ready=1 that cycle; with WB_BYPASS=0 ready=1 the following cycle.
- WAW depth (CNT_W=2): three issues to rd=7 give cnt=3. A fourth writer to rd=7 must stall. One writeback to 7 then lets it fire.
- Dual writeback: cnt[3]=2. wb ports 0 and 1 both retire rd=3 in the same cycle; cnt becomes 0 and busy_o[3]=0 next cycle.
- Flush and error: pend x4 and x9, then pulse flush_i; idle_o must be 1 next cycle. A later wb to rd=4 must set err_o=1 and keep cnt at 0.
- x0 handling: issue with rd=0 and wen=1, then offer rs1=0 and rs2=0 used. idle_o stays 1 and there is never a stall.
